// File: rtl/myproject_mac_pipe_if.sv
// Handshake bundle for myproject_mac_pipe: input beat channel plus result channel.
// The master drives beats and accepts results; the MAC itself attaches as slave.
`timescale 1ns/1ps
interface myproject_mac_pipe_if #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 25
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] dout;
    logic                  dout_ovf;

    modport master (
        output in_valid, din0, din1, in_last, out_ready,
        input  in_ready, out_valid, dout, dout_ovf
    );

    modport slave (
        input  in_valid, din0, din1, in_last, out_ready,
        output in_ready, out_valid, dout, dout_ovf
    );
endinterface

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply-accumulate with valid/ready handshakes and narrowed output.
// Build option MYPROJECT_MAC_SAT_EN: clamp dout on overflow instead of two's-complement wrap.
`timescale 1ns/1ps
module myproject_mac_pipe #(
    parameter int din0_WIDTH  = 16,
    parameter int din1_WIDTH  = 9,
    parameter int DIN1_SIGNED = 0,
    parameter int dout_WIDTH  = 25,
    parameter int NUM_STAGE   = 1,
    parameter int ACC_MODE    = 0,
    parameter int ACC_GUARD   = 4
) (
    input logic                 ap_clk,
    input logic                 ap_rst_n,
    myproject_mac_pipe_if.slave bus
);
    localparam int PROD_W = din0_WIDTH + din1_WIDTH;
    localparam int ACC_W  = PROD_W + ACC_GUARD;

    logic                    en_s;
    logic signed [PROD_W:0]  din0_ext_s;
    logic signed [PROD_W:0]  din1_ext_s;
    logic signed [PROD_W:0]  prod_full_s;
    logic signed [ACC_W-1:0] prod_s;
    logic signed [ACC_W-1:0] fin_data_s;
    logic                    fin_vld_s;
    logic                    fin_last_s;
    logic                    emit_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [dout_WIDTH-1:0]   narrow_s;
    logic                    ovf_s;
    logic signed [ACC_W-1:0] acc_r;
    logic                    out_valid_r;
    logic [dout_WIDTH-1:0]   dout_r;
    logic                    dout_ovf_r;

    // One global enable: the whole pipe freezes while a result waits unconsumed.
    assign en_s         = !out_valid_r || bus.out_ready;
    assign bus.in_ready = en_s;

    // Both operands widened to the exact product width so the multiply is lossless.
    assign din0_ext_s  = (PROD_W + 1)'($signed(bus.din0));
    assign din1_ext_s  = (DIN1_SIGNED != 0) ? (PROD_W + 1)'($signed(bus.din1))
                                            : (PROD_W + 1)'(bus.din1);
    assign prod_full_s = din0_ext_s * din1_ext_s;
    assign prod_s      = ACC_W'(prod_full_s);

    generate
        if (NUM_STAGE > 1) begin : g_pipe
            localparam int D = NUM_STAGE - 1;
            logic signed [ACC_W-1:0] data_r [D];
            logic [D-1:0]            vld_r;
            logic [D-1:0]            last_r;

            // Product delay line; bubbles travel with their valid bit cleared.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    vld_r  <= '0;
                    last_r <= '0;
                    for (int k = 0; k < D; k++) begin
                        data_r[k] <= '0;
                    end
                end else if (en_s) begin
                    vld_r[0]  <= bus.in_valid;
                    last_r[0] <= bus.in_last;
                    data_r[0] <= prod_s;
                    for (int k = 1; k < D; k++) begin
                        vld_r[k]  <= vld_r[k-1];
                        last_r[k] <= last_r[k-1];
                        data_r[k] <= data_r[k-1];
                    end
                end
            end

            assign fin_data_s = data_r[D-1];
            assign fin_vld_s  = vld_r[D-1];
            assign fin_last_s = last_r[D-1];
        end else begin : g_direct
            assign fin_data_s = prod_s;
            assign fin_vld_s  = bus.in_valid;
            assign fin_last_s = bus.in_last;
        end
    endgenerate

    assign emit_s = (ACC_MODE == 0) || fin_last_s;
    assign sum_s  = acc_r + fin_data_s;

    generate
        if (dout_WIDTH >= ACC_W) begin : g_wide
            assign narrow_s = dout_WIDTH'(sum_s);
            assign ovf_s    = 1'b0;
        end else begin : g_narrow
            localparam int HW = ACC_W - dout_WIDTH + 1;
            logic [HW-1:0] head_s;

            // The sum fits iff every bit from the dout sign bit upward equals the sum sign.
            assign head_s = sum_s[ACC_W-1:dout_WIDTH-1];
            assign ovf_s  = (head_s != {HW{sum_s[ACC_W-1]}});
`ifdef MYPROJECT_MAC_SAT_EN
            assign narrow_s = !ovf_s ? sum_s[dout_WIDTH-1:0]
                            : (sum_s[ACC_W-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                              : {1'b0, {(dout_WIDTH-1){1'b1}}});
`else
            assign narrow_s = sum_s[dout_WIDTH-1:0];
`endif
        end
    endgenerate

    // Final stage: accumulate, emit on the closing beat, otherwise retire the old result.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            dout_r      <= '0;
            dout_ovf_r  <= 1'b0;
        end else if (en_s) begin
            if (fin_vld_s && emit_s) begin
                dout_r      <= narrow_s;
                dout_ovf_r  <= ovf_s;
                out_valid_r <= 1'b1;
                acc_r       <= '0;
            end else if (fin_vld_s) begin
                acc_r       <= sum_s;
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.dout      = dout_r;
    assign bus.dout_ovf  = dout_ovf_r;
endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Directed bench for myproject_mac_pipe: four configurations side by side, hand-computed results.
`timescale 1ns/1ps
module tb_myproject_mac_pipe;
    logic ap_clk;
    logic ap_rst_n;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    myproject_mac_pipe_if if0 ();
    myproject_mac_pipe_if if1 ();
    myproject_mac_pipe_if if2 ();
    myproject_mac_pipe_if if3 ();

    myproject_mac_pipe u0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if0));
    myproject_mac_pipe #(.NUM_STAGE(3))   u1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if1));
    myproject_mac_pipe #(.ACC_MODE(1))    u2 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if2));
    myproject_mac_pipe #(.DIN1_SIGNED(1)) u3 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if3));

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int          tx;
        int          rx;
        logic        acc_hs;
        logic        out_hs;
        logic [24:0] held;
        int          sat_exp;

        ap_rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.din0 = 16'd0; if0.din1 = 9'd0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.din0 = 16'd0; if1.din1 = 9'd0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
        if2.in_valid = 1'b0; if2.din0 = 16'd0; if2.din1 = 9'd0; if2.in_last = 1'b0; if2.out_ready = 1'b1;
        if3.in_valid = 1'b0; if3.din0 = 16'd0; if3.din1 = 9'd0; if3.in_last = 1'b0; if3.out_ready = 1'b1;
        repeat (2) @(negedge ap_clk);

        check_val("rst_out_valid", if0.out_valid, 0);
        check_val("rst_in_ready", if0.in_ready, 1);
        check_val("rst_dout", $signed(if0.dout), 0);
        check_val("rst_ovf", if0.dout_ovf, 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // Defaults: single-stage product path
        if0.in_valid = 1'b1; if0.din0 = 16'sh8000; if0.din1 = 9'd511;
        @(negedge ap_clk);
        check_val("def_valid", if0.out_valid, 1);
        check_val("def_dout_neg", $signed(if0.dout), -16744448);
        check_val("def_ovf", if0.dout_ovf, 0);
        if0.din0 = 16'sd100; if0.din1 = 9'h1FF;
        @(negedge ap_clk);
        check_val("def_dout_unsigned", $signed(if0.dout), 51100);
        if0.in_valid = 1'b0;
        @(negedge ap_clk);
        check_val("def_idle_valid", if0.out_valid, 0);

        // Three-stage pipe, ten back-to-back beats
        for (int c = 0; c < 13; c++) begin
            if1.in_valid = (c < 10); if1.din0 = 16'(c); if1.din1 = 9'd2;
            @(posedge ap_clk);
            @(negedge ap_clk);
            check_val("s3_valid", if1.out_valid, (c >= 2 && c < 12));
            if (c >= 2 && c < 12) check_val("s3_dout", $signed(if1.dout), 2 * (c - 2));
        end

        // Backpressure: consumer stalls for five cycles mid-stream
        tx = 0; rx = 0; held = '0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            if1.in_valid  = (tx < 6);
            if1.din0      = 16'(20 + tx);
            if1.din1      = 9'd3;
            if1.out_ready = !(c >= 4 && c <= 8);
            #1;
            if (c >= 4 && c <= 8) begin
                check_val("bp_in_ready", if1.in_ready, 0);
                check_val("bp_out_valid", if1.out_valid, 1);
                if (c == 4) held = if1.dout;
                else check_val("bp_dout_hold", $signed(if1.dout), $signed(held));
            end
            acc_hs = if1.in_valid && if1.in_ready;
            out_hs = if1.out_valid && if1.out_ready;
            if (out_hs) begin
                check_val("bp_dout", $signed(if1.dout), 3 * (20 + rx));
                rx++;
            end
            @(posedge ap_clk);
            if (acc_hs) tx++;
            @(negedge ap_clk);
        end
        check_val("bp_tx_count", tx, 6);
        check_val("bp_rx_count", rx, 6);
        check_val("bp_no_dup", if1.out_valid, 0);
        if1.out_ready = 1'b1;

        // Accumulate three beats into one overflowing result
`ifdef MYPROJECT_MAC_SAT_EN
        sat_exp = 16777215;
`else
        sat_exp = 16677379;
`endif
        for (int b = 0; b < 3; b++) begin
            if2.in_valid = 1'b1; if2.din0 = 16'sd32767; if2.din1 = 9'd511; if2.in_last = (b == 2);
            @(negedge ap_clk);
            check_val("acc_valid", if2.out_valid, (b == 2));
        end
        check_val("acc_dout", $signed(if2.dout), sat_exp);
        check_val("acc_ovf", if2.dout_ovf, 1);
        if2.in_valid = 1'b0; if2.in_last = 1'b0;
        @(negedge ap_clk);
        check_val("acc_single_pulse", if2.out_valid, 0);

        // Reset mid-packet discards the partial sum
        if2.in_valid = 1'b1; if2.din0 = 16'sd5; if2.din1 = 9'd6; if2.in_last = 1'b0;
        repeat (2) @(negedge ap_clk);
        if2.in_valid = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        check_val("rstmid_out_valid", if2.out_valid, 0);
        check_val("rstmid_dout", $signed(if2.dout), 0);
        check_val("rstmid_ovf", if2.dout_ovf, 0);
        check_val("rstmid_in_ready", if2.in_ready, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        if2.in_valid = 1'b1; if2.din0 = 16'sd3; if2.din1 = 9'd4; if2.in_last = 1'b1;
        @(negedge ap_clk);
        check_val("rstmid_fresh_valid", if2.out_valid, 1);
        check_val("rstmid_fresh_dout", $signed(if2.dout), 12);
        check_val("rstmid_fresh_ovf", if2.dout_ovf, 0);
        if2.in_valid = 1'b0; if2.in_last = 1'b0;

        // Signed din1
        if3.in_valid = 1'b1; if3.din0 = 16'sd100; if3.din1 = 9'h1FF;
        @(negedge ap_clk);
        check_val("sgn_dout", $signed(if3.dout), -100);
        if3.din0 = -16'sd200; if3.din1 = 9'h1FE;
        @(negedge ap_clk);
        check_val("sgn_dout_negneg", $signed(if3.dout), 400);
        check_val("sgn_valid", if3.out_valid, 1);
        if3.in_valid = 1'b0;
        @(negedge ap_clk);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/myproject_mac_pipe.md
# myproject_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit with valid/ready handshakes, sitting alongside the combinational DSP multiplier wrappers in the generated dense-layer datapath. It generalises the fixed 16s×9ns multiply to configurable operand widths, operand signedness, pipeline depth, and an optional accumulate-over-a-packet mode, with overflow detection on the narrowed output. It is intended for folded (reuse factor > 1) layers where one DSP computes a whole dot product serially.

## Interface
- din0_WIDTH, 16: width of din0, always signed.
- din1_WIDTH, 9: width of din1.
- DIN1_SIGNED, 0: 1 means din1 is signed; 0 means zero-extended.
- dout_WIDTH, 25: output width, signed.
- NUM_STAGE, 1: cycles from input accept to result register, at least 1.
- ACC_MODE, 0: 0 means every beat emits its product; 1 means beats accumulate until in_last.
- ACC_GUARD, 4: extra accumulator bits; ACC_W = din0_WIDTH + din1_WIDTH + ACC_GUARD.
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- din0  in  din0_WIDTH  signed operand.
- din1  in  din1_WIDTH  operand, signedness per DIN1_SIGNED.
- in_last  in  1  last beat of a packet; ignored when ACC_MODE=0.
- out_valid  out  1  dout/dout_ovf valid.
- out_ready  in  1  consumer accepts result.
- dout  out  dout_WIDTH  result.
- dout_ovf  out  1  result did not fit in dout_WIDTH signed.

## Operation
- Accept occurs when in_valid && in_ready. Product = din0 × ext(din1), exact, din0_WIDTH+din1_WIDTH bits, sign-extended to ACC_W.
- Pipeline: NUM_STAGE−1 product registers, each with a valid and last bit, followed by one final stage holding the accumulator and output register. With NUM_STAGE=1, the product feeds the final stage directly.
- Global stall: en = !out_valid || out_ready. in_ready = en. When en=0, all stages hold. Bubbles are not collapsed.
- Final stage, on en with a valid beat arriving:
  - sum = acc + product, in ACC_W bits, wrapping.
  - If the beat emits (ACC_MODE=0 or last=1): result register ← sum, out_valid ← 1, acc ← 0.
  - Otherwise: acc ← sum, and out_valid ← 0 if the old result was consumed.
- Final stage, on en with no valid beat arriving: out_valid ← 0.
- Narrowing: dout_ovf = 1 iff sum lies outside [−2^(dout_WIDTH−1), 2^(dout_WIDTH−1)−1]. dout value is defined under Configuration.
- If dout_WIDTH ≥ ACC_W, dout is sign-extended and dout_ovf stays 0.
- Accumulator overflow beyond ACC_W wraps silently. Sizing ACC_GUARD is the caller's responsibility.
- Simultaneous events:
  - An emitting beat arriving while the old result is consumed that same cycle replaces it with no gap, so one result is delivered per cycle.
  - Back-to-back in_last beats each emit their own product plus the prior accumulation.

## Timing
- Latency: a beat accepted at edge N appears at the final stage at edge N+NUM_STAGE−1. out_valid is high after edge N+NUM_STAGE−1 when there is no stall.
- Throughput: one beat per cycle while out_ready=1.
- Outputs are registered. in_ready is combinational from out_valid and out_ready.
- Reset asserted, at any time including mid-packet: all stage valids, acc, dout, dout_ovf and out_valid go to 0 immediately. In-flight beats and partial sums are discarded. in_ready=1 during and after reset.
- out_valid, dout and dout_ovf hold stable while out_valid && !out_ready.

## Configuration
- MYPROJECT_MAC_SAT_EN defined: on overflow, dout is clamped to 2^(dout_WIDTH−1)−1 or −2^(dout_WIDTH−1) according to the sign of sum.
- MYPROJECT_MAC_SAT_EN undefined: dout = sum[dout_WIDTH−1:0], a two's-complement wrap.
- dout_ovf behaves identically in both builds.

## Test plan
- Defaults, NUM_STAGE=1, ACC_MODE=0: din0=−32768, din1=511 → dout=−16744448, dout_ovf=0, one cycle after accept.
- NUM_STAGE=3, 10 back-to-back beats, din0=i, din1=2 → dout sequence 0,2,…,18, first result 3 cycles after the first accept, one per cycle thereafter.
- ACC_MODE=1, 3 beats of 32767×511 with in_last on the third:
  - Only one out_valid pulse; dout_ovf=1.
  - With SAT_EN: dout=16777215. Without SAT_EN: dout=16677379.
- Backpressure: hold out_ready=0 for 5 cycles with a pipeline of NUM_STAGE=3 → in_ready=0, dout stable, no beat lost or duplicated after release.
- Reset mid-packet: ACC_MODE=1, 2 beats accepted, then ap_rst_n pulsed low → outputs 0. A new single in_last beat of 3×4 → dout=12, so no stale accumulation.
- DIN1_SIGNED=1: din0=100, din1=9'h1FF → dout=−100.
